// File: rtl/serial_loader_pkg.sv
// Shared constants for the serial loader: default timing/session sizes and
// the FSM state encoding.
package serial_loader_pkg;

  localparam int CLKS_PER_BIT_DEF = 87;
  localparam int MAX_BYTES_DEF    = 16;

  localparam logic [2:0] ST_IDLE    = 3'd0;
  localparam logic [2:0] ST_START   = 3'd1;
  localparam logic [2:0] ST_DATA    = 3'd2;
  localparam logic [2:0] ST_STOP    = 3'd3;
  localparam logic [2:0] ST_RECOVER = 3'd4;

  // Terminal count of the bit timer (down-counter reaching zero).
  function automatic logic timer_expired(input logic [7:0] t);
    return (t == 8'd0);
  endfunction

endpackage

// File: rtl/serial_loader_sync2.sv
// Two-flop synchronizer for an asynchronous single-bit input.
module sync2 #(
  parameter logic RST_VAL = 1'b1
) (
  input  logic clk_i,
  input  logic rst_ni,
  input  logic d_i,
  output logic q_o
);

  logic meta_q;
  logic sync_q;

  // Two back-to-back flops; both reset to the idle level of the line.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      meta_q <= RST_VAL;
      sync_q <= RST_VAL;
    end else begin
      meta_q <= d_i;
      sync_q <= meta_q;
    end
  end

  assign q_o = sync_q;

endmodule

// File: rtl/serial_loader.sv
// UART-style (8N1) byte receiver that feeds a downstream programmer with up
// to MAX_BYTES bytes per session, strobing new_byte once per accepted byte.
//
// state   | meaning
// IDLE    | line idle, waiting for a low level (start bit)
// START   | half-bit wait, confirm start bit at its centre
// DATA    | sample 8 data bits at bit centres, LSB first
// STOP    | sample stop bit; high accepts the byte, low is a framing error
// RECOVER | after a framing error, wait for the line to return high
module serial_loader
  import serial_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = CLKS_PER_BIT_DEF,
  parameter int MAX_BYTES    = MAX_BYTES_DEF
) (
  input  logic       clk,
  input  logic       resetn,
  input  logic       rx,
  input  logic       enable,
  output logic [7:0] data_out,
  output logic       new_byte,
  output logic       frame_err,
  output logic [4:0] byte_count,
  output logic       done
);

  localparam logic [7:0] HALF_BIT = 8'(CLKS_PER_BIT / 2 - 1);
  localparam logic [7:0] FULL_BIT = 8'(CLKS_PER_BIT - 1);
  localparam logic [4:0] MAX_CNT  = 5'(MAX_BYTES);

  logic       rx_s;
  logic [2:0] state_q, state_d;
  logic [7:0] timer_q, timer_d;
  logic [2:0] idx_q, idx_d;
  logic [7:0] shift_q, shift_d;
  logic [7:0] data_q, data_d;
  logic       nb_q, nb_d;
  logic       ferr_q, ferr_d;
  logic [4:0] cnt_q, cnt_d;
  logic       done_w;
  logic       expired;

  sync2 #(.RST_VAL(1'b1)) u_sync (
    .clk_i  (clk),
    .rst_ni (resetn),
    .d_i    (rx),
    .q_o    (rx_s)
  );

  assign done_w  = (cnt_q == MAX_CNT);
  assign expired = timer_expired(timer_q);

  // Next-state logic: frame decoding, bit timer, shifter and session counter.
  always_comb begin
    state_d = state_q;
    timer_d = timer_q;
    idx_d   = idx_q;
    shift_d = shift_q;
    data_d  = data_q;
    nb_d    = 1'b0;
    ferr_d  = ferr_q;
    cnt_d   = cnt_q;
    if (!enable) begin
      // Session closed: abort any frame, keep the last byte for the programmer.
      state_d = ST_IDLE;
      timer_d = 8'd0;
      idx_d   = 3'd0;
      cnt_d   = 5'd0;
      ferr_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!rx_s && !done_w) begin
            state_d = ST_START;
            timer_d = HALF_BIT;
          end
        end
        ST_START: begin
          if (expired) begin
            if (!rx_s) begin
              state_d = ST_DATA;
              timer_d = FULL_BIT;
              idx_d   = 3'd0;
            end else begin
              state_d = ST_IDLE;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        ST_DATA: begin
          if (expired) begin
            shift_d[idx_q] = rx_s;
            timer_d        = FULL_BIT;
            idx_d          = idx_q + 3'd1;
            if (idx_q == 3'd7) state_d = ST_STOP;
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        ST_STOP: begin
          if (expired) begin
            if (rx_s) begin
              data_d  = shift_q;
              nb_d    = 1'b1;
              if (cnt_q != MAX_CNT) cnt_d = cnt_q + 5'd1;
              state_d = ST_IDLE;
            end else begin
              ferr_d  = 1'b1;
              state_d = ST_RECOVER;
            end
          end else begin
            timer_d = timer_q - 8'd1;
          end
        end
        ST_RECOVER: begin
          if (rx_s) state_d = ST_IDLE;
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  // State registers.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q <= ST_IDLE;
      timer_q <= 8'd0;
      idx_q   <= 3'd0;
      shift_q <= 8'h00;
      data_q  <= 8'h00;
      nb_q    <= 1'b0;
      ferr_q  <= 1'b0;
      cnt_q   <= 5'd0;
    end else begin
      state_q <= state_d;
      timer_q <= timer_d;
      idx_q   <= idx_d;
      shift_q <= shift_d;
      data_q  <= data_d;
      nb_q    <= nb_d;
      ferr_q  <= ferr_d;
      cnt_q   <= cnt_d;
    end
  end

  assign data_out   = data_q;
  assign new_byte   = nb_q;
  assign frame_err  = ferr_q;
  assign byte_count = cnt_q;
  assign done       = done_w;

endmodule

// File: tb/tb_serial_loader.sv
// Randomized scoreboard bench for serial_loader at CLKS_PER_BIT = 8.
module tb_serial_loader;

  localparam int CPB = 8;
  localparam int MAXB = 16;

  logic       clk = 1'b0;
  logic       resetn;
  logic       rx;
  logic       enable;
  logic [7:0] data_out;
  logic       new_byte;
  logic       frame_err;
  logic [4:0] byte_count;
  logic       done;

  serial_loader #(.CLKS_PER_BIT(CPB), .MAX_BYTES(MAXB)) dut (
    .clk        (clk),
    .resetn     (resetn),
    .rx         (rx),
    .enable     (enable),
    .data_out   (data_out),
    .new_byte   (new_byte),
    .frame_err  (frame_err),
    .byte_count (byte_count),
    .done       (done)
  );

  always #5 clk = ~clk;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model of the session, updated at frame level.
  int         cnt_m  = 0;
  bit         ferr_m = 0;
  logic [7:0] last_m = 8'h00;
  logic [12:0] exp_q[$];   // {data[7:0], count[4:0]}

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Drive one 8N1 frame. drop_bit < 8 drops enable mid-way through that bit.
  task automatic send_frame(input logic [7:0] d, input bit stop_ok, input int drop_bit);
    if (drop_bit < 8) begin
      cnt_m  = 0;
      ferr_m = 0;
    end else if (enable && cnt_m < MAXB) begin
      if (stop_ok) begin
        cnt_m++;
        last_m = d;
        exp_q.push_back({d, 5'(cnt_m)});
      end else begin
        ferr_m = 1;
      end
    end
    rx = 1'b0;
    tick(CPB);
    for (int i = 0; i < 8; i++) begin
      rx = d[i];
      if (i == drop_bit) begin
        tick(CPB / 2);
        enable = 1'b0;
        tick(CPB - CPB / 2);
      end else begin
        tick(CPB);
      end
    end
    rx = stop_ok;
    tick(CPB);
    rx = 1'b1;
    tick($urandom_range(2, 20));
    if (drop_bit < 8) begin
      enable = 1'b1;
      tick(2);
    end
  endtask

  task automatic new_session();
    enable = 1'b0;
    tick(2);
    enable = 1'b1;
    tick(2);
    cnt_m  = 0;
    ferr_m = 0;
  endtask

  task automatic check_state(input string tag);
    chk({tag, "_cnt"},  32'(byte_count), 32'(cnt_m));
    chk({tag, "_ferr"}, 32'(frame_err),  32'(ferr_m));
    chk({tag, "_done"}, 32'(done),       32'(cnt_m == MAXB));
    chk({tag, "_data"}, 32'(data_out),   32'(last_m));
  endtask

  // Monitor: every strobe pops one expected byte; strobes never back-to-back.
  logic prev_nb = 1'b0;
  always @(negedge clk) begin
    if (new_byte) begin
      n_checks++;
      if (prev_nb) begin
        n_fail++;
        $display("FAIL strobe_spacing: new_byte high on consecutive cycles");
      end
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_strobe: data_out=%0h byte_count=%0d, none expected", data_out, byte_count);
      end else begin
        logic [12:0] e;
        e = exp_q.pop_front();
        chk("strobe_data", 32'(data_out),   32'(e[12:5]));
        chk("strobe_cnt",  32'(byte_count), 32'(e[4:0]));
      end
    end
    prev_nb = new_byte;
  end

  initial begin
    resetn = 1'b0;
    enable = 1'b0;
    rx     = 1'b1;
    tick(3);
    chk("rst_data", 32'(data_out), 32'h00);
    chk("rst_nb",   32'(new_byte), 32'h0);
    chk("rst_cnt",  32'(byte_count), 32'h0);
    chk("rst_ferr", 32'(frame_err), 32'h0);
    chk("rst_done", 32'(done), 32'h0);
    resetn = 1'b1;
    tick(3);
    enable = 1'b1;
    tick(2);

    // Single byte
    send_frame(8'hA5, 1'b1, 8);
    check_state("a5");

    // Fill a session, then one more that must be ignored
    new_session();
    chk("sess_clr", 32'(byte_count), 32'h0);
    for (int i = 0; i < MAXB; i++) begin
      send_frame(8'(i), 1'b1, 8);
      if (i == MAXB - 2) chk("done_early", 32'(done), 32'h0);
    end
    check_state("full");
    send_frame(8'hFF, 1'b1, 8);
    check_state("sat");

    // Framing error then good byte
    new_session();
    send_frame(8'h3C, 1'b0, 8);
    chk("ferr_set", 32'(frame_err), 32'h1);
    send_frame(8'h11, 1'b1, 8);
    check_state("ferr");

    // Glitch shorter than half a bit
    rx = 1'b0;
    tick(3);
    rx = 1'b1;
    tick(3 * CPB);
    check_state("glitch");

    // Enable dropped during data bit 4
    send_frame(8'h77, 1'b1, 4);
    check_state("drop");
    send_frame(8'h22, 1'b1, 8);
    check_state("after_drop");

    // Reset in the middle of a frame
    rx = 1'b0;
    tick(CPB);
    rx = 1'b1;
    tick(2 * CPB + 3);
    #2 resetn = 1'b0;
    #1;
    chk("mrst_data", 32'(data_out), 32'h00);
    chk("mrst_nb",   32'(new_byte), 32'h0);
    chk("mrst_cnt",  32'(byte_count), 32'h0);
    chk("mrst_ferr", 32'(frame_err), 32'h0);
    chk("mrst_done", 32'(done), 32'h0);
    cnt_m  = 0;
    ferr_m = 0;
    last_m = 8'h00;
    tick(3);
    resetn = 1'b1;
    tick(4);
    send_frame(8'h5A, 1'b1, 8);
    check_state("post_rst");

    // Randomized session, long enough to saturate sometimes
    for (int s = 0; s < 3; s++) begin
      new_session();
      for (int k = 0; k < 20; k++)
        send_frame(8'($urandom), ($urandom_range(0, 3) != 0), 8);
      check_state("rand");
    end

    tick(20);
    chk("missing_strobes", 32'(exp_q.size()), 32'h0);
    $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/serial_loader.md
SERIAL_LOADER -- requirements
Module: serial_loader

Interface
REQ-001 Parameter CLKS_PER_BIT, default 87, meaning clk cycles per UART bit time (legal range 8..255).
REQ-002 Parameter MAX_BYTES, default 16, meaning number of bytes accepted per programming session (one per RAM location).
REQ-003 clk  input  1  system clock; all state changes on posedge clk.
REQ-004 resetn  input  1  reset; one clock, reset is asynchronous and active-low.
REQ-005 rx  input  1  asynchronous serial line, 8N1, LSB first, idle high.
REQ-006 enable  input  1  programming session active; low holds the block idle and clears the session.
REQ-007 data_out  output  8  last accepted byte; drives the downstream programmer's byte input.
REQ-008 new_byte  output  1  one-cycle strobe marking data_out valid and new.
REQ-009 frame_err  output  1  sticky flag: a stop bit sampled low this session.
REQ-010 byte_count  output  5  bytes accepted this session, 0..MAX_BYTES.
REQ-011 done  output  1  high when byte_count == MAX_BYTES.

Function
REQ-012 rx SHALL pass through a two-flop synchronizer; all decoding SHALL use the synchronized signal (rx_s), adding 2 cycles of latency.
REQ-013 FSM states SHALL be IDLE, START, DATA, STOP and RECOVER.
REQ-014 IDLE: on rx_s == 0 with enable == 1 and done == 0, the FSM SHALL go to START and load the bit timer with CLKS_PER_BIT/2 - 1.
REQ-015 START: on timer expiry, rx_s == 0 SHALL go to DATA with timer = CLKS_PER_BIT - 1 and bit index = 0; rx_s == 1 (glitch) SHALL return to IDLE with no output change.
REQ-016 DATA: on each timer expiry the FSM SHALL shift rx_s into bit[index] and reload the timer; after bit 7 it SHALL go to STOP.
REQ-017 STOP: on timer expiry with rx_s == 1, the block SHALL update data_out, pulse new_byte high for exactly one cycle, increment byte_count, and go to IDLE.
REQ-018 STOP: on timer expiry with rx_s == 0, the block SHALL discard the byte, set frame_err, leave data_out and byte_count unchanged, and go to RECOVER.
REQ-019 RECOVER SHALL wait for rx_s == 1 and then go to IDLE.
REQ-020 data_out SHALL stay stable from the new_byte cycle until the next accepted byte.
REQ-021 new_byte SHALL never be high on two consecutive cycles, and the minimum spacing between strobes SHALL be 9*CLKS_PER_BIT cycles (at least 72, which exceeds the downstream 7-cycle write sequence).
REQ-022 When byte_count reaches MAX_BYTES, done SHALL assert, and further start bits SHALL be ignored: no strobe and no count wrap.
REQ-023 enable falling, including mid-frame, SHALL force IDLE on the next cycle and clear byte_count, frame_err and done; data_out SHALL be retained.
REQ-024 enable rising SHALL start a new session at byte_count = 0; a line already low at that instant SHALL be treated as a start edge.
REQ-025 The bit timer SHALL be 8 bits wide and the bit index 3 bits wide; byte_count SHALL saturate at MAX_BYTES.

Reset
REQ-026 resetn low SHALL immediately force: FSM = IDLE, synchronizer flops = 1, timer = 0, index = 0, data_out = 8'h00, new_byte = 0, frame_err = 0, byte_count = 0, done = 0.
REQ-027 After reset release, the first frame SHALL be recognised no earlier than 2 cycles later (synchronizer fill).

Structure
REQ-028 A shared package SHALL hold the FSM state encoding, CLKS_PER_BIT default and MAX_BYTES default.
REQ-029 The synchronizer SHALL be a separate sub-module named sync2 (2-flop, reset value parameterised, here 1).
REQ-030 Everything else SHALL remain in serial_loader: FSM, timer, shifter and counter.

Verification (CLKS_PER_BIT = 8)
REQ-031 enable=1, send 8'hA5 with a valid stop bit -> one new_byte pulse, data_out=8'hA5, byte_count=1, frame_err=0.
REQ-032 Send 16 bytes 8'h00..8'h0F, then 8'hFF -> 16 strobes, done=1 after the 16th, no strobe for 8'hFF, data_out=8'h0F, byte_count=16.
REQ-033 Send 8'h3C with the stop bit held low, then 8'h11 -> no strobe for the first frame, frame_err=1, 8'h11 accepted, byte_count=1.
REQ-034 rx low pulse of 3 cycles -> FSM returns to IDLE, no strobe, byte_count unchanged.
REQ-035 Drop enable during data bit 4 of 8'h77, then restore it and send 8'h22 -> no strobe for 8'h77, byte_count cleared, 8'h22 accepted with byte_count=1.
REQ-036 Assert resetn low mid-frame -> all outputs at reset values immediately; a subsequent clean frame 8'h5A is accepted.
